ysyx_220053_ifid_queue: RTL and testbench

Fetch-to-decode buffer between the instruction fetch unit and the decode unit. Captures each fetched (pc, instr) pair into a small FIFO, presents the oldest entry to decode under a valid/ready handshake, and back-pressures fetch through a block signal when full. A flush discards all queued instructions on a control-flow redirect, and a drained queue presents a canonical NOP bubble.

---
 rtl/ysyx_220053_ifid_queue_pkg.sv | 19 +
 rtl/ysyx_220053_ifid_queue.sv | 107 ++++++++++
 tb/tb_ysyx_220053_ifid_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_ifid_queue_pkg.sv
// Shared fetch/decode definitions: pc width, the NOP bubble encoding and the
// {pc, instr} payload carried from fetch to decode.
package ysyx_220053_ifid_queue_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned DROPS_W = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifid_entry_t;

  localparam ifid_entry_t BUBBLE = '{pc: '0, instr: NOP};

endpackage

// File: rtl/ysyx_220053_ifid_queue.sv
// Fetch-to-decode FIFO: buffers (pc, instr) pairs, back-pressures fetch when
// full, discards everything on a redirect flush and shows a NOP bubble when empty.
module ysyx_220053_ifid_queue
  import ysyx_220053_ifid_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [XLEN-1:0]             in_pc,
  input  logic [ILEN-1:0]             in_instr,
  output logic                        in_ready,
  output logic                        block,
  output logic                        out_valid,
  output logic [XLEN-1:0]             out_pc,
  output logic [ILEN-1:0]             out_instr,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DROPS_W-1:0]          flush_drops
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifid_entry_t              mem [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;

  logic                     push;
  logic                     pop;
  logic [PTR_W-1:0]         rd_next;
  logic [PTR_W-1:0]         wr_next;
  logic [CNT_W-1:0]         cnt_next;
  logic [DROPS_W-1:0]       drops_next;
  logic [DROPS_W:0]         drops_sum;
  ifid_entry_t              in_entry;
  ifid_entry_t              head_next;

  // in_ready/out_valid are registered, so push/pop never see a same-cycle pass-through
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign in_entry = '{pc: in_pc, instr: in_instr};

  // Next pointer/occupancy state; flush overrides any push or pop in the same cycle
  always_comb begin
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    cnt_next   = count;
    drops_next = flush_drops;
    drops_sum  = (DROPS_W+1)'(flush_drops) + (DROPS_W+1)'(count);
    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      cnt_next   = '0;
      drops_next = drops_sum[DROPS_W] ? '1 : drops_sum[DROPS_W-1:0];
    end else begin
      if (push) wr_next = PTR_W'(wr_ptr + PTR_W'(1));
      if (pop)  rd_next = PTR_W'(rd_ptr + PTR_W'(1));
      unique case ({push, pop})
        2'b10:   cnt_next = CNT_W'(count + CNT_W'(1));
        2'b01:   cnt_next = CNT_W'(count - CNT_W'(1));
        default: cnt_next = count;
      endcase
    end
  end

  // Head seen by decode after this edge; bypass the write that lands in the head slot
  always_comb begin
    head_next = BUBBLE;
    if (cnt_next != '0) begin
      if (push && !flush && (rd_next == wr_ptr)) head_next = in_entry;
      else                                       head_next = mem[rd_next];
    end
  end

  // Payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !flush && rst) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flush_drops <= '0;
      in_ready    <= 1'b1;
      block       <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= NOP;
    end else begin
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      count       <= cnt_next;
      flush_drops <= drops_next;
      in_ready    <= (cnt_next < CNT_W'(DEPTH));
      block       <= !(cnt_next < CNT_W'(DEPTH));
      out_valid   <= (cnt_next != '0);
      out_pc      <= head_next.pc;
      out_instr   <= head_next.instr;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_ifid_queue.sv
// Bench for the fetch-to-decode queue: scoreboard model plus table-driven
// vectors and hand-written reset/flush/saturation sequences.
module tb_ysyx_220053_ifid_queue;
  import ysyx_220053_ifid_queue_pkg::*;

  localparam int DEPTH = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [XLEN-1:0]   in_pc;
  logic [ILEN-1:0]   in_instr;
  logic              in_ready;
  logic              block;
  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [ILEN-1:0]   out_instr;
  logic              out_ready;
  logic              flush;
  logic [1:0]        count;
  logic [31:0]       flush_drops;

  int checks;
  int errors;

  ifid_entry_t mq[$];
  logic [31:0] m_drops;

  typedef struct {
    bit          iv;
    logic [63:0] pc;
    logic [31:0] instr;
    bit          ordy;
    bit          fl;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  ysyx_220053_ifid_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .block(block),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .flush(flush),
    .count(count), .flush_drops(flush_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the scoreboard head / model state
  task automatic chk_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"},     64'(count),     64'(sz));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(sz < DEPTH));
    chk({tag, ".block"},     64'(block),     64'(sz >= DEPTH));
    chk({tag, ".drops"},     64'(flush_drops), 64'(m_drops));
    if (sz != 0) begin
      chk({tag, ".out_pc"},    out_pc,           mq[0].pc);
      chk({tag, ".out_instr"}, 64'(out_instr),   64'(mq[0].instr));
    end else begin
      chk({tag, ".out_pc"},    out_pc,           64'h0);
      chk({tag, ".out_instr"}, 64'(out_instr),   64'h13);
    end
  endtask

  // One cycle: drive at negedge, check, clock, update scoreboard
  task automatic step(input string tag, input bit iv, input logic [63:0] pc,
                      input logic [31:0] ins, input bit ordy, input bit fl);
    bit m_push, m_pop;
    logic [32:0] s;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk_model(tag);
    m_push = iv && (mq.size() < DEPTH);
    m_pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      s = 33'(m_drops) + 33'(mq.size());
      m_drops = s[32] ? 32'hFFFF_FFFF : s[31:0];
      mq.delete();
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back('{pc: pc, instr: ins});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0297;
  endfunction

  initial begin
    checks = 0; errors = 0; m_drops = '0;
    rst = 1'b0; in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'h0000_0297;
    out_ready = 1'b0; flush = 1'b0;

    // Reset held with fetch presenting data
    repeat (3) @(negedge clk);
    chk("rst.count",     64'(count),     64'h0);
    chk("rst.out_valid", 64'(out_valid), 64'h0);
    chk("rst.out_instr", 64'(out_instr), 64'h13);
    chk("rst.out_pc",    out_pc,         64'h0);
    chk("rst.block",     64'(block),     64'h0);
    chk("rst.in_ready",  64'(in_ready),  64'h1);
    rst = 1'b1;

    step("first", 1, 64'h8000_0000, 32'h0000_0297, 0, 0);
    chk("first.out_valid", 64'(out_valid), 64'h1);
    chk("first.out_pc",    out_pc,         64'h8000_0000);
    chk("first.out_instr", 64'(out_instr), 64'h297);
    step("drain0", 0, 0, 0, 1, 0);

    // Fill / back-pressure vector table
    vecs.push_back('{1, 64'h8000_0000, 32'h0, 0, 0, 1});
    vecs.push_back('{1, 64'h8000_0004, 32'h0, 0, 0, 2});
    vecs.push_back('{1, 64'h8000_0008, 32'h0, 0, 0, 2});
    vecs.push_back('{1, 64'h8000_0008, 32'h0, 1, 0, 1});
    vecs.push_back('{1, 64'h8000_0008, 32'h0, 1, 0, 1});
    vecs.push_back('{0, 64'h0,         32'h0, 1, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("fill%0d", i), vecs[i].iv, vecs[i].pc, ins_of(vecs[i].pc),
           vecs[i].ordy, vecs[i].fl);
      chk($sformatf("fill%0d.cnt", i), 64'(count), 64'(vecs[i].exp_cnt));
    end

    // Streaming with pointer wrap
    for (int i = 0; i < 20; i++) begin
      logic [63:0] p;
      p = 64'h8000_0100 + 64'(4 * i);
      step($sformatf("strm%0d", i), 1, p, ins_of(p), 1, 0);
      chk($sformatf("strm%0d.cnt", i), 64'(count), 64'h1);
    end
    step("strm_end", 0, 0, 0, 1, 0);

    // Flush while full with push and pop offered
    step("fl_a", 1, 64'h8000_0200, ins_of(64'h8000_0200), 0, 0);
    step("fl_b", 1, 64'h8000_0204, ins_of(64'h8000_0204), 0, 0);
    step("fl_c", 1, 64'h8000_0208, ins_of(64'h8000_0208), 1, 1);
    chk("flush.cnt",   64'(count),       64'h0);
    chk("flush.valid", 64'(out_valid),   64'h0);
    chk("flush.drops", 64'(flush_drops), 64'h2);
    chk("flush.ready", 64'(in_ready),    64'h1);
    step("redir", 1, 64'h8000_1000, ins_of(64'h8000_1000), 0, 0);
    chk("redir.pc",  out_pc,      64'h8000_1000);
    chk("redir.cnt", 64'(count),  64'h1);
    step("redir_pop", 0, 0, 0, 1, 0);
    step("redir_empty", 0, 0, 0, 0, 0);

    // Saturation of flush_drops
    step("sat_a", 1, 64'h8000_0300, ins_of(64'h8000_0300), 0, 0);
    step("sat_b", 1, 64'h8000_0304, ins_of(64'h8000_0304), 0, 0);
    force dut.flush_drops = 32'hFFFF_FFFE;
    #1;
    release dut.flush_drops;
    m_drops = 32'hFFFF_FFFE;
    step("sat_fl", 0, 0, 0, 0, 1);
    chk("sat.drops", 64'(flush_drops), 64'hFFFF_FFFF);
    step("sat_after", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges with one entry queued
    step("ar_push", 1, 64'h8000_0400, ins_of(64'h8000_0400), 0, 0);
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.count",     64'(count),       64'h0);
    chk("arst.out_valid", 64'(out_valid),   64'h0);
    chk("arst.out_pc",    out_pc,           64'h0);
    chk("arst.out_instr", 64'(out_instr),   64'h13);
    chk("arst.block",     64'(block),       64'h0);
    chk("arst.drops",     64'(flush_drops), 64'h0);
    mq.delete();
    m_drops = '0;
    @(negedge clk);
    @(negedge clk);
    chk("arst.hold_cnt", 64'(count), 64'h0);
    rst = 1'b1;
    step("post_rst", 1, 64'h8000_0500, ins_of(64'h8000_0500), 0, 0);
    step("post_rst_pop", 0, 0, 0, 1, 0);
    step("final", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
